// File: rtl/bt_frame_pkg.sv
// bt_frame_pkg: shared constants and state type for the bluetooth IMU frame parser
package bt_frame_pkg;
  localparam int FRAME_LEN = 11;
  localparam logic [7:0] FRAME_HEADER_DEF = 8'h55;
  localparam logic [7:0] TYPE_ACC = 8'h51;
  localparam logic [7:0] TYPE_GYR = 8'h52;
  localparam logic [7:0] TYPE_ANG = 8'h53;
  typedef enum logic [1:0] {IDLE, SUM, CHECK} state_t;
endpackage

// File: rtl/bt_frame_checksum.sv
// bt_frame_checksum: serial mod-256 sum over bytes 0..9 of a captured frame, one byte per cycle
module bt_frame_checksum import bt_frame_pkg::*; (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic [8*(FRAME_LEN-1)-1:0] data,
  output logic [7:0]                 sum,
  output logic                       done
);
  logic [3:0] idx;
  // done marks the edge that folds in the final summed byte
  assign done = idx == 4'd9;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      sum <= '0;
    end else if (clr) begin
      idx <= '0;
      sum <= '0;
    end else if (en) begin
      sum <= sum + data[{idx, 3'b000} +: 8];
      idx <= idx + 4'd1;
    end
  end
endmodule

// File: rtl/bt_frame_parser.sv
// bt_frame_parser: validates 11-byte IMU frames and splits them into acc/gyr/ang registers
// BT_FRAME_PARSER_CHECKSUM_EN adds serial checksum verification (latency 11, else 1)
module bt_frame_parser import bt_frame_pkg::*; #(
  parameter int         RX_DATA_BYTE_WIDTH = FRAME_LEN,
  parameter logic [7:0] FRAME_HEADER       = FRAME_HEADER_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [8*RX_DATA_BYTE_WIDTH-1:0] rx_data,
  input  logic                            rx_rdy,
  output logic                            rx_ack,
  output logic [15:0]                     acc_x,
  output logic [15:0]                     acc_y,
  output logic [15:0]                     acc_z,
  output logic [15:0]                     gyr_x,
  output logic [15:0]                     gyr_y,
  output logic [15:0]                     gyr_z,
  output logic [15:0]                     ang_x,
  output logic [15:0]                     ang_y,
  output logic [15:0]                     ang_z,
  output logic [2:0]                      upd,
  output logic [15:0]                     frame_cnt,
  output logic [15:0]                     err_cnt
);
  state_t state, nxt;
  logic [8*RX_DATA_BYTE_WIDTH-1:0] shadow;
  logic accept, good;
  logic [2:0] hit;
  logic [15:0] w0, w1, w2;
  assign accept = state == IDLE && rx_rdy;
  assign w0 = shadow[31:16];
  assign w1 = shadow[47:32];
  assign w2 = shadow[63:48];
  assign hit = {shadow[15:8] == TYPE_ANG, shadow[15:8] == TYPE_GYR, shadow[15:8] == TYPE_ACC};
`ifdef BT_FRAME_PARSER_CHECKSUM_EN
  logic [7:0] sum;
  logic done;
  bt_frame_checksum u_sum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state == SUM),
    .data (shadow[79:0]),
    .sum  (sum),
    .done (done)
  );
  assign good = shadow[7:0] == FRAME_HEADER && sum == shadow[87:80];
  always_comb begin
    nxt = accept ? SUM : state == SUM ? (done ? CHECK : SUM) : IDLE;
  end
`else
  assign good = shadow[7:0] == FRAME_HEADER;
  always_comb begin
    nxt = accept ? CHECK : IDLE;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      rx_ack <= 1'b0;
      upd <= '0;
      {acc_x, acc_y, acc_z} <= '0;
      {gyr_x, gyr_y, gyr_z} <= '0;
      {ang_x, ang_y, ang_z} <= '0;
      frame_cnt <= '0;
      err_cnt <= '0;
    end else begin
      rx_ack <= accept;
      upd <= '0;
      if (accept) shadow <= rx_data;
      if (state == CHECK && !good && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (state == CHECK && good) begin
        upd <= hit;
        if (|hit) frame_cnt <= frame_cnt + 16'd1;
        if (hit[0]) {acc_z, acc_y, acc_x} <= {w2, w1, w0};
        if (hit[1]) {gyr_z, gyr_y, gyr_x} <= {w2, w1, w0};
        if (hit[2]) {ang_z, ang_y, ang_x} <= {w2, w1, w0};
      end
    end
  end
endmodule
